// File: rtl/axi5_burst_addr_gen_if.sv
// Descriptor and beat bundle for axi5_burst_addr_gen. The master modport is the upstream decoder and
// beat consumer; the slave modport is the generator itself.
interface axi5_burst_addr_gen_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic [1:0]        req_burst;
  logic              beat_valid;
  logic              beat_ready;
  logic [ID_W-1:0]   beat_id;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_idx;
  logic              beat_last;
  logic [1:0]        beat_resp;

  modport master (
    output req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    input  req_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_resp
  );

  modport slave (
    input  req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    output req_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_resp
  );
endinterface

// File: rtl/axi5_burst_addr_gen.sv
// AXI5 per-beat address generator: takes one burst descriptor and emits len+1 addressed beats.
// Optional 4 KB crossing check on INCR bursts is enabled by defining AXI5_BOUNDARY_CHECK_EN.
module axi5_burst_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  axi5_burst_addr_gen_if.slave   bus
);
  typedef enum logic [1:0] {BurstFixed = 2'b00, BurstIncr = 2'b01, BurstWrap = 2'b10,
                            BurstRsvd = 2'b11} AXBurst_t;
  typedef logic [2:0] AXSize_t;
  typedef enum logic [1:0] {RespOkay = 2'b00, RespExokay = 2'b01, RespSlverr = 2'b10,
                            RespDecerr = 2'b11} XRESP_t;
  typedef enum logic {StIdle, StBurst} state_t;

  localparam int unsigned MaxSize = $clog2(DATA_W / 8);

  state_t            r_state, w_state_next;
  logic              r_init;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_idx, r_len;
  AXSize_t           r_size;
  logic [1:0]        r_burst;
  XRESP_t            r_resp;

  logic              w_req_hs, w_beat_hs, w_last, w_req_err, w_cross;
  logic [ADDR_W-1:0] w_req_bytes, w_req_aligned;
  logic [ADDR_W-1:0] w_bytes, w_aligned, w_incr, w_container, w_base, w_addr_next;

  assign bus.req_ready  = (r_state == StIdle) && r_init;
  assign bus.beat_valid = (r_state == StBurst);
  assign bus.beat_id    = r_id;
  assign bus.beat_addr  = r_addr;
  assign bus.beat_idx   = r_idx;
  assign bus.beat_resp  = r_resp;
  assign w_last         = (r_idx == r_len);
  assign bus.beat_last  = bus.beat_valid && w_last;

  assign w_req_hs  = bus.req_valid && bus.req_ready;
  assign w_beat_hs = bus.beat_valid && bus.beat_ready;

  // Classification of the incoming descriptor, frozen into r_resp at acceptance.
  assign w_req_bytes   = ADDR_W'(1) << bus.req_size;
  assign w_req_aligned = bus.req_addr & ~(w_req_bytes - ADDR_W'(1));

`ifdef AXI5_BOUNDARY_CHECK_EN
  logic [ADDR_W-1:0] w_req_span;
  logic [ADDR_W:0]   w_req_end;
  assign w_req_span = w_req_bytes * ({{(ADDR_W-8){1'b0}}, bus.req_len} + ADDR_W'(1));
  // Extra top bit makes a wrap past 2^ADDR_W count as a crossing too.
  assign w_req_end  = {1'b0, w_req_aligned} + {1'b0, w_req_span} - (ADDR_W+1)'(1);
  assign w_cross    = (bus.req_burst == BurstIncr) &&
                      (w_req_end[ADDR_W:12] != {1'b0, w_req_aligned[ADDR_W-1:12]});
`else
  assign w_cross = 1'b0;
`endif

  assign w_req_err = (bus.req_burst == BurstRsvd) ||
                     (bus.req_size > 3'(MaxSize)) ||
                     ((bus.req_burst == BurstWrap) &&
                      !(bus.req_len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                     w_cross;

  // Next-beat address from the registered burst state.
  assign w_bytes     = ADDR_W'(1) << r_size;
  assign w_aligned   = r_addr & ~(w_bytes - ADDR_W'(1));
  assign w_incr      = w_aligned + w_bytes;
  assign w_container = w_bytes * ({{(ADDR_W-8){1'b0}}, r_len} + ADDR_W'(1));
  assign w_base      = r_addr & ~(w_container - ADDR_W'(1));

  always_comb begin
    w_addr_next = r_addr;
    if (r_resp == RespOkay) begin
      unique case (r_burst)
        BurstIncr: w_addr_next = w_incr;
        BurstWrap: w_addr_next = (w_incr == w_base + w_container) ? w_base : w_incr;
        default:   w_addr_next = r_addr;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_req_hs) w_state_next = StBurst;
      StBurst: if (w_beat_hs && w_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_init  <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_resp  <= RespOkay;
    end else begin
      r_state <= w_state_next;
      r_init  <= 1'b1;
      if (w_req_hs) begin
        r_id    <= bus.req_id;
        r_addr  <= bus.req_addr;
        r_idx   <= '0;
        r_len   <= bus.req_len;
        r_size  <= bus.req_size;
        r_burst <= bus.req_burst;
        r_resp  <= w_req_err ? RespSlverr : RespOkay;
      end else if (w_beat_hs && !w_last) begin
        r_addr <= w_addr_next;
        r_idx  <= r_idx + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi5_burst_addr_gen.sv
// Directed table-driven bench for axi5_burst_addr_gen (DATA_W=64), plus reset and backpressure
// sequences; expectations follow AXI5_BOUNDARY_CHECK_EN when it is defined.
module tb_axi5_burst_addr_gen;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef struct {
    logic [1:0]        burst;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        resp;
    int                stall;
    logic [15:0][31:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[10];

  axi5_burst_addr_gen_if #(.ADDR_W(32), .ID_W(4)) bus ();

  axi5_burst_addr_gen #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] burst, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] resp,
                         input int stall, input logic [511:0] exp_addr);
    vecs[i].burst    = burst;
    vecs[i].addr     = addr;
    vecs[i].len      = len;
    vecs[i].size     = size;
    vecs[i].resp     = resp;
    vecs[i].stall    = stall;
    vecs[i].exp_addr = exp_addr;
  endtask

  task automatic send_req(input logic [3:0] id, input logic [1:0] burst, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
    int t = 0;
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_id    = id;
    bus.req_burst = burst;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_size  = size;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v = vecs[vi];
    send_req(4'(vi), v.burst, v.addr, v.len, v.size);
    for (int b = 0; b <= int'(v.len); b++) begin
      if (b == v.stall) begin
        bus.beat_ready = 1'b0;
        repeat (5) begin
          chk("stall_valid", 32'(bus.beat_valid), 32'd1);
          chk("stall_addr", bus.beat_addr, v.exp_addr[b]);
          chk("stall_idx", 32'(bus.beat_idx), 32'(b));
          chk("stall_last", 32'(bus.beat_last), 32'd0);
          @(negedge clk);
        end
        bus.beat_ready = 1'b1;
      end
      chk("beat_valid", 32'(bus.beat_valid), 32'd1);
      chk("beat_addr", bus.beat_addr, v.exp_addr[b]);
      chk("beat_idx", 32'(bus.beat_idx), 32'(b));
      chk("beat_last", 32'(bus.beat_last), 32'(b == int'(v.len)));
      chk("beat_resp", 32'(bus.beat_resp), 32'(v.resp));
      chk("beat_id", 32'(bus.beat_id), 32'(vi));
      @(negedge clk);
    end
    chk("valid_after_last", 32'(bus.beat_valid), 32'd0);
    chk("req_ready_after_last", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_size   = '0;
    bus.req_burst  = '0;
    bus.beat_ready = 1'b1;

    set_vec(0, INCR, 32'h1003, 8'd3, 3'd2, OKAY, -1,
            512'({32'h100C, 32'h1008, 32'h1004, 32'h1003}));
    set_vec(1, WRAP, 32'h2034, 8'd3, 3'd2, OKAY, -1,
            512'({32'h2030, 32'h203C, 32'h2038, 32'h2034}));
    set_vec(2, FIXED, 32'h40, 8'd2, 3'd3, OKAY, -1, 512'({32'h40, 32'h40, 32'h40}));
    set_vec(3, WRAP, 32'h100, 8'd2, 3'd2, SLVERR, -1, 512'({32'h100, 32'h100, 32'h100}));
    set_vec(4, RSVD, 32'h80, 8'd0, 3'd2, SLVERR, -1, 512'(32'h80));
    set_vec(5, INCR, 32'h500, 8'd1, 3'd7, SLVERR, -1, 512'({32'h500, 32'h500}));
    set_vec(6, INCR, 32'h300, 8'd7, 3'd3, OKAY, 2,
            512'({32'h338, 32'h330, 32'h328, 32'h320, 32'h318, 32'h310, 32'h308, 32'h300}));
    set_vec(7, WRAP, 32'h1038, 8'd7, 3'd3, OKAY, -1,
            512'({32'h1030, 32'h1028, 32'h1020, 32'h1018, 32'h1010, 32'h1008, 32'h1000,
                  32'h1038}));
    set_vec(8, INCR, 32'h7, 8'd0, 3'd0, OKAY, -1, 512'(32'h7));
`ifdef AXI5_BOUNDARY_CHECK_EN
    set_vec(9, INCR, 32'hFF8, 8'd3, 3'd2, SLVERR, -1,
            512'({32'hFF8, 32'hFF8, 32'hFF8, 32'hFF8}));
`else
    set_vec(9, INCR, 32'hFF8, 8'd3, 3'd2, OKAY, -1,
            512'({32'h1004, 32'h1000, 32'hFFC, 32'hFF8}));
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_beat_valid", 32'(bus.beat_valid), 32'd0);
    chk("rst_beat_addr", bus.beat_addr, 32'd0);
    chk("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
    chk("rst_beat_last", 32'(bus.beat_last), 32'd0);
    chk("rst_beat_id", 32'(bus.beat_id), 32'd0);
    chk("rst_beat_resp", 32'(bus.beat_resp), 32'(OKAY));
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset pulsed mid-burst at beat 4.
    send_req(4'hA, INCR, 32'h200, 8'd7, 3'd3);
    repeat (4) @(negedge clk);
    chk("mid_idx", 32'(bus.beat_idx), 32'd4);
    chk("mid_addr", bus.beat_addr, 32'h220);
    bus.beat_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.beat_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_idx", 32'(bus.beat_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.beat_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready_after", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_valid_after", 32'(bus.beat_valid), 32'd0);

    // Generator still works after the aborted burst.
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
